vga_pixel2num: RTL and testbench

- Readback decoder for the 9-segment digit renderer: watches the VGA pixel stream and samples one pixel per segment inside a configured digit box.
- Classifies each sample as foreground or background using the active theme colours, then decodes the 9-bit segment pattern back to a digit code.
- Sits beside the VGA output mux as a self-test monitor. It reports the decoded number, a lock status and error pulses.

---
 rtl/vga_pixel2num.sv | 177 +++++++++++++++++
 tb/tb_vga_pixel2num.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel2num.sv
// Self-test readback monitor: samples nine segment points of a rendered digit in the
// VGA stream, classifies them against the frame's theme colours and decodes the digit.
module vga_pixel2num #(
  parameter logic [9:0] X0     = 10'd100,
  parameter logic [9:0] Y0     = 10'd100,
  parameter logic [9:0] W      = 10'd40,
  parameter logic [9:0] H      = 10'd80,
  parameter int         STABLE = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sof,
  input  logic        valid,
  input  logic [9:0]  h_cnt,
  input  logic [9:0]  v_cnt,
  input  logic [11:0] pixel,
  input  logic [1:0]  theme,
  output logic [3:0]  num_out,
  output logic        num_valid,
  output logic        locked,
  output logic        frame_err
);

  localparam logic [9:0] XL = X0;
  localparam logic [9:0] XM = X0 + W / 10'd2;
  localparam logic [9:0] XR = X0 + W;
  localparam logic [9:0] YT = Y0;
  localparam logic [9:0] Y1 = Y0 + H / 10'd4;
  localparam logic [9:0] YM = Y0 + H / 10'd2;
  localparam logic [9:0] Y3 = Y0 + (H / 10'd4) * 10'd3;
  localparam logic [9:0] YB = Y0 + H;
  localparam logic [2:0] STABLE_C = 3'(STABLE);

  typedef enum logic [1:0] {SYNC, CAPTURE, DECODE} state_t;

  state_t      state, state_nxt;
  logic [1:0]  theme_q, theme_eff;
  logic [11:0] fg, bg;
  logic [8:0]  pt, samp;
  logic [8:0]  cap_bits, cap_hit, dec_bits, dec_hit;
  logic [8:0]  bits_nxt, hit_nxt;
  logic        cap_bad, dec_bad, bad_nxt;
  logic        take_sof, sampling;
  logic [3:0]  code, candidate;
  logic        code_ok, good;
  logic [2:0]  count, cnt_nxt;

  // A sof arriving during the one-cycle DECODE slot is dropped.
  assign take_sof  = sof && (state != DECODE);
  assign sampling  = (state != SYNC) || sof;
  assign theme_eff = take_sof ? theme : theme_q;

  always_comb begin
    bg = 12'h000;
    fg = 12'hfff;
    case (theme_eff)
      2'b01:   begin bg = 12'hfff; fg = 12'h000; end
      2'b10:   begin bg = 12'he7d; fg = 12'h8f0; end
      default: ;
    endcase
  end

  always_comb begin
    pt[0] = (h_cnt == XM) && (v_cnt == YT);
    pt[1] = (h_cnt == XR) && (v_cnt == Y1);
    pt[2] = (h_cnt == XR) && (v_cnt == Y3);
    pt[3] = (h_cnt == XM) && (v_cnt == YB);
    pt[4] = (h_cnt == XL) && (v_cnt == Y3);
    pt[5] = (h_cnt == XL) && (v_cnt == Y1);
    pt[6] = (h_cnt == XM) && (v_cnt == YM);
    pt[7] = (h_cnt == XL) && (v_cnt == YM);
    pt[8] = (h_cnt == XR) && (v_cnt == YM);
  end

  // The sof-cycle pixel is folded in on top of the cleared capture set.
  always_comb begin
    samp     = valid ? pt : 9'd0;
    hit_nxt  = (take_sof ? 9'd0 : cap_hit) | samp;
    bits_nxt = ((take_sof ? 9'd0 : cap_bits) & ~samp) | (samp & {9{pixel == fg}});
    bad_nxt  = (take_sof ? 1'b0 : cap_bad) | ((|samp) && (pixel != fg) && (pixel != bg));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SYNC:    if (sof) state_nxt = CAPTURE;
      CAPTURE: if (sof) state_nxt = DECODE;
      DECODE:  state_nxt = CAPTURE;
      default: state_nxt = SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= SYNC;
      theme_q  <= 2'd0;
      cap_bits <= 9'd0;
      cap_hit  <= 9'd0;
      cap_bad  <= 1'b0;
      dec_bits <= 9'd0;
      dec_hit  <= 9'd0;
      dec_bad  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (take_sof) theme_q <= theme;
      if (take_sof && state == CAPTURE) begin
        dec_bits <= cap_bits;
        dec_hit  <= cap_hit;
        dec_bad  <= cap_bad;
      end
      if (sampling) begin
        cap_bits <= bits_nxt;
        cap_hit  <= hit_nxt;
        cap_bad  <= bad_nxt;
      end
    end
  end

  always_comb begin
    code_ok = 1'b1;
    code    = 4'd11;
    case (dec_bits)
      9'b1_1011_1111: code = 4'd0;
      9'b1_0000_0110: code = 4'd1;
      9'b1_1101_1011: code = 4'd2;
      9'b1_0100_1111: code = 4'd3;
      9'b1_1110_0110: code = 4'd4;
      9'b1_1110_1101: code = 4'd5;
      9'b1_1111_1101: code = 4'd6;
      9'b1_0000_0111: code = 4'd7;
      9'b1_1111_1111: code = 4'd8;
      9'b1_1110_0111: code = 4'd9;
      9'b1_1100_0000: code = 4'd10;
      9'b0_0000_0000: code = 4'd11;
      default:        code_ok = 1'b0;
    endcase
    good = (&dec_hit) && !dec_bad && code_ok;
  end

  always_comb begin
    cnt_nxt = 3'd1;
    if (code == candidate) cnt_nxt = (count >= STABLE_C) ? STABLE_C : count + 3'd1;
  end

  // Candidate tracking: an error frame breaks the run but keeps the candidate.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      num_out   <= 4'd11;
      num_valid <= 1'b0;
      locked    <= 1'b0;
      frame_err <= 1'b0;
      candidate <= 4'd11;
      count     <= 3'd0;
    end else begin
      num_valid <= 1'b0;
      frame_err <= 1'b0;
      if (state == DECODE) begin
        if (!good) begin
          frame_err <= 1'b1;
          count     <= 3'd0;
          locked    <= 1'b0;
        end else begin
          candidate <= code;
          count     <= cnt_nxt;
          if (cnt_nxt >= STABLE_C) begin
            num_out   <= code;
            locked    <= 1'b1;
            num_valid <= 1'b1;
          end else begin
            locked <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_pixel2num.sv
// Directed bench for vga_pixel2num: short synthetic frames touching only the sample
// points, a frame-level model predicting each decode two cycles after the next sof.
module tb_vga_pixel2num;

  localparam int X0 = 100, Y0 = 100, W = 40, H = 80, STABLE = 2;

  logic        clk = 1'b0;
  logic        rst_n, sof, valid;
  logic [9:0]  h_cnt, v_cnt;
  logic [11:0] pixel;
  logic [1:0]  theme;
  logic [3:0]  num_out;
  logic        num_valid, locked, frame_err;

  vga_pixel2num dut (
    .clk(clk), .rst_n(rst_n), .sof(sof), .valid(valid), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .pixel(pixel), .theme(theme), .num_out(num_out), .num_valid(num_valid),
    .locked(locked), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       when;
    bit       nv;
    bit       fe;
    int       num;
    bit       lk;
  } ev_t;

  ev_t         evq[$];
  ev_t         cur_ev;
  int          cyc = 0;
  int          n_cmp = 0, n_fail = 0;
  int          fe_seen = 0, nv_seen = 0;
  bit          chk_en = 0;
  int          exp_num, exp_nv, exp_fe, exp_lk;
  logic [8:0]  tbl [12];
  logic [11:0] bgc [4], fgc [4];
  int          ptx [9], pty [9];

  // Frame-level model state: lock tracker and the last completed frame's result.
  int m_cand = 11, m_count = 0, m_num = 11;
  bit m_locked = 0, have_prev = 0;
  int prev_res = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      exp_nv = 0;
      exp_fe = 0;
      if (evq.size() > 0 && evq[0].when == cyc) begin
        cur_ev  = evq.pop_front();
        exp_nv  = cur_ev.nv;
        exp_fe  = cur_ev.fe;
        exp_num = cur_ev.num;
        exp_lk  = cur_ev.lk;
      end
      checkOutput("num_out", 32'(num_out), 32'(exp_num));
      checkOutput("locked", 32'(locked), 32'(exp_lk));
      checkOutput("num_valid", 32'(num_valid), 32'(exp_nv));
      checkOutput("frame_err", 32'(frame_err), 32'(exp_fe));
      if (frame_err === 1'b1) fe_seen++;
      if (num_valid === 1'b1) nv_seen++;
    end
  end

  task automatic applyStimulus(input bit s, input bit v, input int hx, input int vy,
                               input logic [11:0] p, input logic [1:0] th, input bit r);
    @(negedge clk);
    rst_n = r;
    sof   = s;
    valid = v;
    h_cnt = 10'(hx);
    v_cnt = 10'(vy);
    pixel = p;
    theme = th;
  endtask

  task automatic modelReset();
    ev_t keep[$];
    ev_t e;
    foreach (evq[k]) if (evq[k].when <= cyc) keep.push_back(evq[k]);
    evq = keep;
    e.when = cyc + 1; e.nv = 0; e.fe = 0; e.num = 11; e.lk = 0;
    evq.push_back(e);
    m_cand = 11; m_count = 0; m_num = 11; m_locked = 0; have_prev = 0;
  endtask

  // The previous frame's verdict becomes visible two cycles after this sof.
  task automatic modelDecodePrev();
    ev_t e;
    if (!have_prev) return;
    e.when = cyc + 2; e.nv = 0; e.fe = 0;
    if (prev_res < 0) begin
      e.fe = 1; m_count = 0; m_locked = 0;
    end else begin
      if (prev_res == m_cand) m_count = (m_count < STABLE) ? m_count + 1 : STABLE;
      else begin m_cand = prev_res; m_count = 1; end
      if (m_count >= STABLE) begin m_num = prev_res; m_locked = 1; e.nv = 1; end
      else m_locked = 0;
    end
    e.num = m_num; e.lk = m_locked;
    evq.push_back(e);
  endtask

  task automatic sendFrame(input int dig, input logic [1:0] t, input int bad_idx,
                           input int miss_idx, input bit rst_mid);
    logic [8:0]  pat;
    logic [11:0] p;
    bit          r;
    int          res;
    pat = tbl[dig];
    r   = 1;
    applyStimulus(1, 1, 0, 0, bgc[t], t, 1);
    modelDecodePrev();
    for (int i = 0; i < 9; i++) begin
      if (rst_mid && i == 5) begin
        applyStimulus(0, 0, 0, 0, 12'h000, t, 0);
        modelReset();
      end
      p = (i == bad_idx) ? 12'h123 : (pat[i] ? fgc[t] : bgc[t]);
      applyStimulus(0, i != miss_idx, ptx[i], pty[i], p, t ^ 2'b01, r);
    end
    applyStimulus(0, 1, X0 + 1, Y0, 12'h5a5, t ^ 2'b01, 1);
    applyStimulus(0, 0, 0, 0, 12'h000, t, 1);
    res = -1;
    if (bad_idx < 0 && miss_idx < 0)
      for (int k = 0; k < 12; k++) if (tbl[k] == pat) res = k;
    have_prev = !rst_mid;
    prev_res  = res;
  endtask

  initial begin
    tbl[0] = 9'b1_1011_1111; tbl[1] = 9'b1_0000_0110; tbl[2]  = 9'b1_1101_1011;
    tbl[3] = 9'b1_0100_1111; tbl[4] = 9'b1_1110_0110; tbl[5]  = 9'b1_1110_1101;
    tbl[6] = 9'b1_1111_1101; tbl[7] = 9'b1_0000_0111; tbl[8]  = 9'b1_1111_1111;
    tbl[9] = 9'b1_1110_0111; tbl[10] = 9'b1_1100_0000; tbl[11] = 9'b0_0000_0000;
    bgc[0] = 12'h000; fgc[0] = 12'hfff; bgc[1] = 12'hfff; fgc[1] = 12'h000;
    bgc[2] = 12'he7d; fgc[2] = 12'h8f0; bgc[3] = 12'h000; fgc[3] = 12'hfff;
    ptx[0] = X0 + W/2; pty[0] = Y0;         ptx[1] = X0 + W;   pty[1] = Y0 + H/4;
    ptx[2] = X0 + W;   pty[2] = Y0 + 3*H/4; ptx[3] = X0 + W/2; pty[3] = Y0 + H;
    ptx[4] = X0;       pty[4] = Y0 + 3*H/4; ptx[5] = X0;       pty[5] = Y0 + H/4;
    ptx[6] = X0 + W/2; pty[6] = Y0 + H/2;   ptx[7] = X0;       pty[7] = Y0 + H/2;
    ptx[8] = X0 + W;   pty[8] = Y0 + H/2;

    rst_n = 0; sof = 0; valid = 0; h_cnt = 0; v_cnt = 0; pixel = 0; theme = 0;
    exp_num = 11; exp_lk = 0; exp_nv = 0; exp_fe = 0;
    repeat (3) @(negedge clk);
    checkOutput("reset num_out", 32'(num_out), 32'd11);
    checkOutput("reset locked", 32'(locked), 32'd0);
    checkOutput("reset num_valid", 32'(num_valid), 32'd0);
    checkOutput("reset frame_err", 32'(frame_err), 32'd0);
    rst_n  = 1;
    chk_en = 1;

    // Tail of a frame before any sof: must be discarded.
    for (int i = 3; i < 9; i++) applyStimulus(0, 1, ptx[i], pty[i], 12'h123, 2'b00, 1);

    sendFrame(3, 2'b00, -1, -1, 0);
    sendFrame(3, 2'b00, -1, -1, 0);
    checkOutput("d3 first decode locked", 32'(locked), 32'd0);
    checkOutput("d3 first decode num", 32'(num_out), 32'd11);
    sendFrame(3, 2'b00, -1, -1, 0);
    checkOutput("d3 lock num", 32'(num_out), 32'd3);
    checkOutput("d3 lock locked", 32'(locked), 32'd1);

    sendFrame(8, 2'b10, -1, -1, 0);
    checkOutput("d3 pulse count", 32'(nv_seen), 32'd2);
    sendFrame(8, 2'b10, -1, -1, 0);
    sendFrame(8, 2'b10, -1, -1, 0);
    checkOutput("d8 lock num", 32'(num_out), 32'd8);
    sendFrame(1, 2'b10, -1, -1, 0);
    sendFrame(1, 2'b10, -1, -1, 0);
    checkOutput("d1 first num holds 8", 32'(num_out), 32'd8);
    checkOutput("d1 first unlocked", 32'(locked), 32'd0);

    sendFrame(10, 2'b01, -1, -1, 0);
    checkOutput("d1 lock num", 32'(num_out), 32'd1);
    checkOutput("d1 lock locked", 32'(locked), 32'd1);
    sendFrame(10, 2'b01, -1, -1, 0);
    sendFrame(11, 2'b01, -1, -1, 0);
    checkOutput("p10 lock num", 32'(num_out), 32'd10);
    sendFrame(11, 2'b01, -1, -1, 0);

    sendFrame(5, 2'b00, 6, -1, 0);
    checkOutput("p11 lock num", 32'(num_out), 32'd11);
    checkOutput("no errors so far", 32'(fe_seen), 32'd0);
    sendFrame(7, 2'b00, -1, 3, 0);
    checkOutput("bad pixel err count", 32'(fe_seen), 32'd1);
    checkOutput("bad pixel unlocked", 32'(locked), 32'd0);
    checkOutput("bad pixel num holds", 32'(num_out), 32'd11);
    sendFrame(7, 2'b00, -1, -1, 0);
    checkOutput("miss err count", 32'(fe_seen), 32'd2);
    sendFrame(7, 2'b00, -1, -1, 0);
    sendFrame(9, 2'b00, -1, -1, 0);
    checkOutput("d7 lock num", 32'(num_out), 32'd7);
    sendFrame(9, 2'b00, -1, -1, 0);
    sendFrame(9, 2'b00, -1, -1, 0);
    checkOutput("d9 lock num", 32'(num_out), 32'd9);

    sendFrame(9, 2'b00, -1, -1, 1);
    checkOutput("post reset num", 32'(num_out), 32'd11);
    checkOutput("post reset locked", 32'(locked), 32'd0);
    sendFrame(9, 2'b11, -1, -1, 0);
    sendFrame(9, 2'b11, -1, -1, 0);
    checkOutput("relock pending", 32'(locked), 32'd0);
    sendFrame(9, 2'b11, -1, -1, 0);
    checkOutput("relock num", 32'(num_out), 32'd9);
    checkOutput("relock locked", 32'(locked), 32'd1);

    repeat (4) applyStimulus(0, 0, 0, 0, 12'h000, 2'b00, 1);
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
